// File: rtl/aes128_req_ctrl.sv
// Request sequencer between a sop/eop framed block stream and the aes128 core command port.
// Optional WAIT watchdog with err_timeout output: define AES_REQ_TIMEOUT_EN.
module aes128_req_ctrl #(
   parameter int unsigned CHAIN_GAP      = 1,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_sop,
   input  logic         in_eop,
   input  logic [127:0] cfg_key,
   input  logic [127:0] cfg_iv,
   input  logic [3:0]   cfg_mode,
   input  logic         cfg_decrypt,
   input  logic [15:0]  cfg_segment_len,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         out_sop,
   output logic         out_eop,
   output logic         aes_cipher_en,
   output logic         aes_decipher_en,
   output logic         aes_chain_en,
   output logic [127:0] aes_data_in,
   output logic [127:0] aes_key,
   output logic [3:0]   aes_mode,
   output logic [127:0] aes_init_vector,
   output logic [15:0]  aes_segment_len,
   input  logic [127:0] aes_data_out,
   input  logic         aes_ready,
   output logic         busy,
   output logic         err_proto
`ifdef AES_REQ_TIMEOUT_EN
  ,output logic         err_timeout
`endif
);

   localparam int unsigned DW = 128;
   localparam int unsigned MW = 4;
   localparam int unsigned SW = 16;
   localparam int unsigned GW = 4;

   if (CHAIN_GAP < 1 || CHAIN_GAP > 15) begin : g_bad_gap
      $error("CHAIN_GAP must be in 1..15");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_OUT,
      S_BREAK
   } state_t;

   state_t          r_state;
   logic            r_msg_open;
   logic            r_ready_q;
   logic            r_decrypt;
   logic            r_sop;
   logic            r_eop;
   logic            r_brk_issue;
   logic [GW-1:0]   r_gap_cnt;
   logic            r_in_ready;
   logic            r_out_valid;
   logic [DW-1:0]   r_out_data;
   logic            r_out_sop;
   logic            r_out_eop;
   logic            r_cipher_en;
   logic            r_decipher_en;
   logic            r_chain_en;
   logic [DW-1:0]   r_data_in;
   logic [DW-1:0]   r_key;
   logic [MW-1:0]   r_mode;
   logic [DW-1:0]   r_iv;
   logic [SW-1:0]   r_seg;
   logic            r_busy;
   logic            r_err_proto;

`ifdef AES_REQ_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]   r_to_cnt;
   logic            r_err_timeout;
   assign err_timeout = r_err_timeout;
`endif

   // A block without an open message, or with sop, starts a fresh configuration
   logic w_new_cfg;
   logic w_dir;
   assign w_new_cfg = in_sop | ~r_msg_open;
   assign w_dir     = w_new_cfg ? cfg_decrypt : r_decrypt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_msg_open    <= 1'b0;
         r_ready_q     <= 1'b0;
         r_decrypt     <= 1'b0;
         r_sop         <= 1'b0;
         r_eop         <= 1'b0;
         r_brk_issue   <= 1'b0;
         r_gap_cnt     <= '0;
         r_in_ready    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_sop     <= 1'b0;
         r_out_eop     <= 1'b0;
         r_cipher_en   <= 1'b0;
         r_decipher_en <= 1'b0;
         r_chain_en    <= 1'b0;
         r_data_in     <= '0;
         r_key         <= '0;
         r_mode        <= '0;
         r_iv          <= '0;
         r_seg         <= '0;
         r_busy        <= 1'b0;
         r_err_proto   <= 1'b0;
`ifdef AES_REQ_TIMEOUT_EN
         r_to_cnt      <= '0;
         r_err_timeout <= 1'b0;
`endif
      end else begin
         r_cipher_en   <= 1'b0;
         r_decipher_en <= 1'b0;
         r_err_proto   <= 1'b0;
         r_ready_q     <= aes_ready;
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_data_in  <= in_data;
                  r_sop      <= w_new_cfg;
                  r_eop      <= in_eop;
                  if (w_new_cfg) begin
                     r_key      <= cfg_key;
                     r_mode     <= cfg_mode;
                     r_iv       <= cfg_iv;
                     r_seg      <= cfg_segment_len;
                     r_decrypt  <= cfg_decrypt;
                     r_msg_open <= 1'b1;
                  end
`ifdef AES_REQ_TIMEOUT_EN
                  if (in_sop) r_err_timeout <= 1'b0;
`endif
                  if (in_sop == r_msg_open) r_err_proto <= 1'b1;
                  if (in_sop && r_msg_open) begin
                     // restart inside an open message: drop chaining before this block
                     r_chain_en  <= 1'b0;
                     r_gap_cnt   <= GW'(CHAIN_GAP - 1);
                     r_brk_issue <= 1'b1;
                     r_state     <= S_BREAK;
                  end else begin
                     r_chain_en    <= 1'b1;
                     r_cipher_en   <= ~w_dir;
                     r_decipher_en <= w_dir;
                     r_state       <= S_ISSUE;
                  end
               end else begin
                  r_in_ready <= 1'b1;
               end
            end
            S_ISSUE: begin
`ifdef AES_REQ_TIMEOUT_EN
               r_to_cnt <= '0;
`endif
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (aes_ready && !r_ready_q) begin
                  r_out_data  <= aes_data_out;
                  r_out_sop   <= r_sop;
                  r_out_eop   <= r_eop;
                  r_out_valid <= 1'b1;
                  r_state     <= S_OUT;
               end
`ifdef AES_REQ_TIMEOUT_EN
               else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  r_err_timeout <= 1'b1;
                  r_out_data    <= '0;
                  r_out_sop     <= r_sop;
                  r_out_eop     <= 1'b1;
                  r_eop         <= 1'b1;
                  r_out_valid   <= 1'b1;
                  r_state       <= S_OUT;
               end else begin
                  r_to_cnt <= r_to_cnt + TW'(1);
               end
`endif
            end
            S_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_eop) begin
                     r_msg_open  <= 1'b0;
                     r_chain_en  <= 1'b0;
                     r_gap_cnt   <= GW'(CHAIN_GAP - 1);
                     r_brk_issue <= 1'b0;
                     r_state     <= S_BREAK;
                  end else begin
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= S_IDLE;
                  end
               end
            end
            S_BREAK: begin
               if (r_gap_cnt == '0) begin
                  r_chain_en <= 1'b1;
                  if (r_brk_issue) begin
                     r_brk_issue   <= 1'b0;
                     r_cipher_en   <= ~r_decrypt;
                     r_decipher_en <= r_decrypt;
                     r_state       <= S_ISSUE;
                  end else begin
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b0;
                     r_state    <= S_IDLE;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt - GW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready        = r_in_ready;
   assign out_valid       = r_out_valid;
   assign out_data        = r_out_data;
   assign out_sop         = r_out_sop;
   assign out_eop         = r_out_eop;
   assign aes_cipher_en   = r_cipher_en;
   assign aes_decipher_en = r_decipher_en;
   assign aes_chain_en    = r_chain_en;
   assign aes_data_in     = r_data_in;
   assign aes_key         = r_key;
   assign aes_mode        = r_mode;
   assign aes_init_vector = r_iv;
   assign aes_segment_len = r_seg;
   assign busy            = r_busy;
   assign err_proto       = r_err_proto;

endmodule

// File: tb/tb_aes128_req_ctrl.sv
// Directed bench for aes128_req_ctrl with a behavioural aes128 stub returning known OFB vectors.
module tb_aes128_req_ctrl;

   localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT [4] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                                       128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                       128'h30c81c46a35ce411e5fbc1191a0a52ef,
                                       128'hf69f2445df4f9b17ad2b417be66c3710};
   localparam logic [127:0] CT [4] = '{128'h3b3fd92eb72dad20333449f8e83cfb4a,
                                       128'h7789508d16918f03f53c52dac54ed825,
                                       128'h9740051e9c5fecf64344f7a82260edcc,
                                       128'h304c6528f659c77866a510d9c1d6ae5e};

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid, in_ready, in_sop, in_eop;
   logic [127:0] in_data, cfg_key, cfg_iv;
   logic [3:0] cfg_mode;
   logic cfg_decrypt;
   logic [15:0] cfg_segment_len;
   logic out_valid, out_ready, out_sop, out_eop;
   logic [127:0] out_data;
   logic aes_cipher_en, aes_decipher_en, aes_chain_en;
   logic [127:0] aes_data_in, aes_key, aes_init_vector;
   logic [3:0] aes_mode;
   logic [15:0] aes_segment_len;
   logic [127:0] aes_data_out = '0;
   logic aes_ready = 1'b0;
   logic busy, err_proto;
`ifdef AES_REQ_TIMEOUT_EN
   logic err_timeout;
`endif

   always #5 clk = ~clk;

   aes128_req_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sop(in_sop), .in_eop(in_eop),
      .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_mode(cfg_mode),
      .cfg_decrypt(cfg_decrypt), .cfg_segment_len(cfg_segment_len),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sop(out_sop), .out_eop(out_eop),
      .aes_cipher_en(aes_cipher_en), .aes_decipher_en(aes_decipher_en),
      .aes_chain_en(aes_chain_en), .aes_data_in(aes_data_in), .aes_key(aes_key),
      .aes_mode(aes_mode), .aes_init_vector(aes_init_vector),
      .aes_segment_len(aes_segment_len), .aes_data_out(aes_data_out),
      .aes_ready(aes_ready), .busy(busy), .err_proto(err_proto)
`ifdef AES_REQ_TIMEOUT_EN
     ,.err_timeout(err_timeout)
`endif
   );

   // Core stub: drops ready on a start pulse, raises it with the known answer a few cycles later
   logic stall = 1'b0;
   logic pend = 1'b0;
   logic [3:0] lat_cnt = '0;

   function automatic logic [127:0] ref_core(input logic [127:0] d, input logic dec);
      logic [127:0] r;
      r = ~d;
      for (int i = 0; i < 4; i++) begin
         if (!dec && d == PT[i]) r = CT[i];
         if (dec && d == CT[i]) r = PT[i];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (aes_cipher_en || aes_decipher_en) begin
         aes_ready    <= 1'b0;
         pend         <= !stall;
         lat_cnt      <= 4'd3;
         aes_data_out <= ref_core(aes_data_in, aes_decipher_en);
      end else if (pend) begin
         if (lat_cnt == 4'd0) begin
            aes_ready <= 1'b1;
            pend      <= 1'b0;
         end else begin
            lat_cnt <= lat_cnt - 4'd1;
         end
      end
   end

   // Event monitor sampled just after each rising edge
   int n_cipher = 0, n_decipher = 0, n_both = 0, n_nochain = 0, n_perr = 0, n_low = 0;
   always @(posedge clk) begin
      #1;
      if (aes_cipher_en) n_cipher++;
      if (aes_decipher_en) n_decipher++;
      if (aes_cipher_en && aes_decipher_en) n_both++;
      if ((aes_cipher_en || aes_decipher_en) && !aes_chain_en) n_nochain++;
      if (err_proto) n_perr++;
      if (!aes_chain_en) n_low++;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: wait budget expired", name);
   endtask

   typedef struct {
      logic [127:0] data;
      logic sop, eop, dec;
      logic [15:0] seg;
      logic [127:0] exp;
      logic exp_sop, exp_eop;
      int exp_err;
      int exp_low;
   } vec_t;

   function automatic vec_t mk(input logic [127:0] d, input logic s, input logic e, input logic dec,
                               input logic [15:0] seg, input logic [127:0] x, input logic xs,
                               input logic xe, input int xerr, input int xlow);
      vec_t v;
      v.data = d; v.sop = s; v.eop = e; v.dec = dec; v.seg = seg;
      v.exp = x; v.exp_sop = xs; v.exp_eop = xe; v.exp_err = xerr; v.exp_low = xlow;
      return v;
   endfunction

   task automatic send(input vec_t v, output bit ok);
      int n;
      cfg_key = KEY; cfg_iv = IV; cfg_mode = 4'd3;
      cfg_decrypt = v.dec; cfg_segment_len = v.seg;
      in_data = v.data; in_sop = v.sop; in_eop = v.eop; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = in_ready;
      if (!ok) fail("in_ready_wait");
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      int n;
      n = 0;
      while (!out_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      ok = out_valid;
      if (!ok) fail("out_valid_wait");
   endtask

   // Sends one block and checks its result; returns with out_valid shown, accepted on the next edge
   task automatic do_vec(input vec_t v);
      int low0, perr0;
      bit ok;
      low0 = n_low;
      perr0 = n_perr;
      send(v, ok);
      if (ok) wait_out(ok);
      if (ok) begin
         chk("out_data", out_data, v.exp);
         chk("out_sop", 128'(out_sop), 128'(v.exp_sop));
         chk("out_eop", 128'(out_eop), 128'(v.exp_eop));
         chk("err_proto_pulses", 128'(n_perr - perr0), 128'(v.exp_err));
         if (v.exp_low >= 0) chk("chain_low_cycles", 128'(n_low - low0), 128'(v.exp_low));
         chk("cfg_key", aes_key, KEY);
         chk("cfg_iv", aes_init_vector, IV);
         chk("cfg_mode_seg", 128'({aes_mode, aes_segment_len}), 128'({4'd3, v.seg}));
         chk("in_ready_in_out", 128'(in_ready), 128'(0));
      end
   endtask

   vec_t tab [11];

   initial begin
      int c0, d0, p0;
      bit ok;
      vec_t v;
      tab[0]  = mk(PT[0], 1, 0, 0, 16'd0, CT[0], 1, 0, 0, -1);
      tab[1]  = mk(PT[1], 0, 0, 0, 16'd0, CT[1], 0, 0, 0, 0);
      tab[2]  = mk(PT[2], 0, 0, 0, 16'd0, CT[2], 0, 0, 0, 0);
      tab[3]  = mk(PT[3], 0, 1, 0, 16'd0, CT[3], 0, 1, 0, 0);
      tab[4]  = mk(CT[0], 1, 0, 1, 16'd3, PT[0], 1, 0, 0, 1);
      tab[5]  = mk(CT[1], 0, 0, 1, 16'd3, PT[1], 0, 0, 0, 0);
      tab[6]  = mk(CT[2], 0, 0, 1, 16'd3, PT[2], 0, 0, 0, 0);
      tab[7]  = mk(CT[3], 0, 1, 1, 16'd3, PT[3], 0, 1, 0, 0);
      tab[8]  = mk(PT[0], 1, 0, 0, 16'd0, CT[0], 1, 0, 0, 1);
      tab[9]  = mk(PT[1], 0, 0, 0, 16'd0, CT[1], 0, 0, 0, 0);
      tab[10] = mk(PT[2], 1, 1, 0, 16'd0, CT[2], 1, 1, 1, 1);

      rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
      cfg_key = '0; cfg_iv = '0; cfg_mode = '0; cfg_decrypt = 1'b0; cfg_segment_len = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", 128'({in_ready, out_valid, out_sop, out_eop, aes_cipher_en,
                              aes_decipher_en, aes_chain_en, busy, err_proto}), 128'(0));
      chk("reset_data", out_data | aes_data_in | aes_key | aes_init_vector, 128'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 128'(in_ready), 128'(1));

      for (int i = 0; i < 11; i++) begin
         if (i == 0 || i == 4) begin c0 = n_cipher; d0 = n_decipher; end
         do_vec(tab[i]);
         if (i == 3) begin
            chk("enc_cipher_pulses", 128'(n_cipher - c0), 128'(4));
            chk("enc_decipher_pulses", 128'(n_decipher - d0), 128'(0));
         end
         if (i == 7) begin
            chk("dec_decipher_pulses", 128'(n_decipher - d0), 128'(4));
            chk("dec_cipher_pulses", 128'(n_cipher - c0), 128'(0));
         end
      end

      // Back-pressure: result must hold while out_ready is low
      @(negedge clk);
      out_ready = 1'b0;
      send(mk(PT[0], 1, 1, 0, 16'd0, CT[0], 1, 1, 0, -1), ok);
      if (ok) wait_out(ok);
      p0 = n_cipher + n_decipher;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("hold_out_data", out_data, CT[0]);
         chk("hold_ready_valid", 128'({in_ready, out_valid}), 128'(2'b01));
      end
      chk("hold_no_start", 128'(n_cipher + n_decipher - p0), 128'(0));
      out_ready = 1'b1;
      @(negedge clk);

      // Reset while waiting on the core
      send(mk(PT[0], 1, 0, 0, 16'd0, CT[0], 1, 0, 0, -1), ok);
      @(negedge clk);
      chk("pre_reset_wait", 128'({busy, out_valid}), 128'(2'b10));
      rst_n = 1'b0;
      #1;
      chk("async_reset_ctrl", 128'({in_ready, out_valid, out_sop, out_eop, aes_cipher_en,
                                    aes_decipher_en, aes_chain_en, busy, err_proto}), 128'(0));
      chk("async_reset_data", out_data | aes_data_in | aes_key | aes_init_vector, 128'(0));
      chk("async_reset_cfg", 128'({aes_mode, aes_segment_len}), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      do_vec(mk(PT[1], 0, 1, 0, 16'd0, CT[1], 1, 1, 1, -1));
      repeat (4) @(negedge clk);
      chk("final_idle", 128'({busy, in_ready}), 128'(2'b01));

`ifdef AES_REQ_TIMEOUT_EN
      stall = 1'b1;
      send(mk(PT[3], 1, 1, 0, 16'd0, 128'(0), 1, 1, 0, -1), ok);
      if (ok) wait_out(ok);
      chk("timeout_flag", 128'(err_timeout), 128'(1));
      chk("timeout_data", out_data, 128'(0));
      chk("timeout_eop", 128'(out_eop), 128'(1));
      @(negedge clk);
      chk("timeout_break", 128'({aes_chain_en, busy}), 128'(2'b01));
      @(negedge clk);
      chk("timeout_idle", 128'({aes_chain_en, busy, in_ready, err_timeout}), 128'(4'b1011));
      stall = 1'b0;
`endif

      chk("never_both_pulses", 128'(n_both), 128'(0));
      chk("start_without_chain", 128'(n_nochain), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
